data_mem_mmio: RTL and testbench

//  Data-side memory system driven by the cpu's X/M-stage data port (data_addr, mem_write_data,
//  mem_read_en, mem_write_en) and feeding mem_read_data into the M/W pipeline register.

---
 rtl/data_mem_mmio_pkg.sv | 23 ++
 rtl/mmio_defs.vh | 17 +
 rtl/tx_fifo.sv | 59 +++++
 rtl/data_mem_mmio.sv | 116 +++++++++++
 tb/tb_data_mem_mmio.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_mmio_pkg.sv
// Shared types and helpers for the data-side memory / MMIO block.
`include "mmio_defs.vh"

package data_mem_mmio_pkg;

  typedef enum logic [1:0] {
    DEC_RAM,
    DEC_MMIO,
    DEC_NONE
  } dec_e;

  function automatic logic [31:0] status_word(input logic empty, input logic full,
                                              input logic ovf, input logic [7:0] count);
    logic [31:0] w;
    w = '0;
    w[`STATUS_EMPTY_BIT] = empty;
    w[`STATUS_FULL_BIT]  = full;
    w[`STATUS_OVF_BIT]   = ovf;
    w[`STATUS_COUNT_LSB +: `STATUS_COUNT_W] = count;
    return w;
  endfunction

endpackage

// File: rtl/mmio_defs.vh
// MMIO register map shared with the cpu-side test programs: byte offsets inside the
// 16-byte MMIO window and the STATUS register bit positions.
`ifndef MMIO_DEFS_VH
`define MMIO_DEFS_VH

`define MMIO_OFF_TX_DATA 4'h0
`define MMIO_OFF_STATUS  4'h4
`define MMIO_OFF_CYCLE   4'h8
`define MMIO_OFF_RSVD    4'hC

`define STATUS_EMPTY_BIT 0
`define STATUS_FULL_BIT  1
`define STATUS_OVF_BIT   2
`define STATUS_COUNT_LSB 8
`define STATUS_COUNT_W   8

`endif

// File: rtl/tx_fifo.sv
// Byte transmit FIFO: registered storage, combinational head, no push-to-head bypass.
// A push into a full FIFO is only taken together with a pop.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_FULL);
  assign count = r_count;
  // Head reads as zero while empty so stale bytes never leak onto tx_data.
  assign head  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory system: word RAM below MMIO_BASE, a 4-register MMIO window
// (TX FIFO, STATUS, CYCLE) above it; zero-latency reads, writes commit at the edge.
`include "mmio_defs.vh"

module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int          MEM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] mem_write_data,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  output logic [31:0] mem_read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          AW       = $clog2(MEM_WORDS);
  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] MMIO_END = {1'b0, MMIO_BASE} + 33'd16;

  dec_e            w_dec;
  logic [3:0]      w_reg_off;
  logic [AW-1:0]   w_ram_idx;
  logic            w_ram_wr;
  logic            w_tx_wr;
  logic            w_status_wr;
  logic            w_cycle_wr;
  logic            w_pop;
  logic            w_push;
  logic            w_ovf_set;
  logic            w_ovf_clr;
  logic            w_fifo_empty;
  logic            w_fifo_full;
  logic [CW-1:0]   w_fifo_count;
  logic [31:0]     w_rd_mux;
  logic [31:0]     r_ram [MEM_WORDS];
  logic [31:0]     r_cycle;
  logic            r_ovf;

  always_comb begin
    if (data_addr < MMIO_BASE)               w_dec = DEC_RAM;
    else if ({1'b0, data_addr} < MMIO_END)   w_dec = DEC_MMIO;
    else                                     w_dec = DEC_NONE;
  end

  assign w_reg_off   = {data_addr[3:2], 2'b00};
  assign w_ram_idx   = data_addr[AW+1:2];
  assign w_ram_wr    = mem_write_en && (w_dec == DEC_RAM);
  assign w_tx_wr     = mem_write_en && (w_dec == DEC_MMIO) && (w_reg_off == `MMIO_OFF_TX_DATA);
  assign w_status_wr = mem_write_en && (w_dec == DEC_MMIO) && (w_reg_off == `MMIO_OFF_STATUS);
  assign w_cycle_wr  = mem_write_en && (w_dec == DEC_MMIO) && (w_reg_off == `MMIO_OFF_CYCLE);

  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign w_pop     = tx_valid && tx_ready;
  assign w_push    = w_tx_wr && (!w_fifo_full || w_pop);
  assign w_ovf_set = w_tx_wr && w_fifo_full && !w_pop;
  assign w_ovf_clr = w_status_wr && mem_write_data[`STATUS_OVF_BIT];

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (mem_write_data[7:0]),
    .pop       (w_pop),
    .head      (tx_data),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full),
    .count     (w_fifo_count)
  );

  assign tx_valid = !w_fifo_empty;

  always_ff @(posedge clk) begin
    if (w_ram_wr) r_ram[w_ram_idx] <= mem_write_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_cycle <= w_cycle_wr ? mem_write_data : r_cycle + 32'd1;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_dec)
      DEC_RAM:  w_rd_mux = r_ram[w_ram_idx];
      DEC_MMIO: begin
        case (w_reg_off)
          `MMIO_OFF_STATUS: w_rd_mux = status_word(w_fifo_empty, w_fifo_full, r_ovf,
                                                   8'(w_fifo_count));
          `MMIO_OFF_CYCLE:  w_rd_mux = r_cycle;
          default:          w_rd_mux = '0;
        endcase
      end
      default:  w_rd_mux = '0;
    endcase
  end

  assign mem_read_data = mem_read_en ? w_rd_mux : '0;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: the driver pushes expected load data and accepted
// TX bytes into queues; a monitor pops and compares on mem_read_en and tx handshakes.
module tb_data_mem_mmio;

  localparam int          MEM_WORDS  = 256;
  localparam int          FIFO_DEPTH = 8;
  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr;
  logic [31:0] mem_write_data;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  data_mem_mmio #(
    .MEM_WORDS  (MEM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MMIO_BASE  (MMIO_BASE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_addr      (data_addr),
    .mem_write_data (mem_write_data),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] rd_q[$];
  logic [7:0]  sb_tx[$];

  // Reference model state (post-edge view).
  logic [31:0] m_ram [MEM_WORDS];
  logic [7:0]  m_fifo[$];
  logic        m_ovf;
  logic [31:0] m_cycle;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h, expected %08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [31:0] off;
    int unsigned n;
    off = addr - MMIO_BASE;
    n   = m_fifo.size();
    if (addr < MMIO_BASE) return m_ram[int'((addr >> 2) % MEM_WORDS)];
    if (off < 32'd16) begin
      case (off >> 2)
        32'd1:   return ((n == 0) ? 32'd1 : 32'd0) + ((n == FIFO_DEPTH) ? 32'd2 : 32'd0)
                        + (m_ovf ? 32'd4 : 32'd0) + n * 32'd256;
        32'd2:   return m_cycle;
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  task automatic model_commit(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic rdy);
    logic [31:0] off;
    bit pop, acc, set_ovf, clr_ovf, cyc_wr;
    off = addr - MMIO_BASE;
    pop = 0; acc = 0; set_ovf = 0; clr_ovf = 0; cyc_wr = 0;
    if (we && addr < MMIO_BASE) m_ram[int'((addr >> 2) % MEM_WORDS)] = wdata;
    if (rst) begin
      m_fifo.delete();
      m_ovf   = 1'b0;
      m_cycle = 32'd0;
      return;
    end
    pop = (m_fifo.size() > 0) && rdy;
    if (we && addr >= MMIO_BASE && off < 32'd16) begin
      case (off >> 2)
        32'd0: if (m_fifo.size() < FIFO_DEPTH || pop) acc = 1; else set_ovf = 1;
        32'd1: clr_ovf = wdata[2];
        32'd2: cyc_wr = 1;
        default: ;
      endcase
    end
    if (pop) void'(m_fifo.pop_front());
    if (acc) begin
      m_fifo.push_back(wdata[7:0]);
      sb_tx.push_back(wdata[7:0]);
    end
    if (set_ovf)      m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    m_cycle = cyc_wr ? wdata : m_cycle + 32'd1;
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step_x(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic rdy,
                        input bit use_exp, input logic [31:0] exp);
    mem_write_en   = we;
    mem_read_en    = re;
    data_addr      = addr;
    mem_write_data = wdata;
    tx_ready       = rdy;
    if (re) rd_q.push_back(use_exp ? exp : model_read(addr));
    model_commit(we, addr, wdata, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic we, input logic re, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic rdy);
    step_x(we, re, addr, wdata, rdy, 1'b0, 32'd0);
  endtask

  task automatic idle_inputs();
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    tx_ready     = 1'b0;
  endtask

  task automatic monitor();
    logic [31:0] e;
    logic [7:0]  b;
    forever begin
      @(negedge clk);
      if (mem_read_en) begin
        if (rd_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL read_unexpected: got %08h, expected no load", mem_read_data);
        end else begin
          e = rd_q.pop_front();
          $display("rd  addr=%08h we=%0b data=%08h exp=%08h", data_addr, mem_write_en,
                   mem_read_data, e);
          chk("read_data", mem_read_data, e);
        end
      end else begin
        chk("read_idle_zero", mem_read_data, 32'd0);
      end
      if (tx_valid && tx_ready) begin
        if (sb_tx.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL tx_unexpected: got %02h, expected no byte", tx_data);
        end else begin
          b = sb_tx.pop_front();
          $display("tx  byte=%02h exp=%02h", tx_data, b);
          chk("tx_data", {24'h0, tx_data}, {24'h0, b});
        end
      end
    end
  endtask

  int unsigned kind;
  logic        r_we, r_re, r_rdy;
  logic [31:0] r_a, r_d;
  int          k;

  initial begin
    rst = 1'b1;
    mem_read_en = 1'b0; mem_write_en = 1'b0; data_addr = '0; mem_write_data = '0;
    tx_ready = 1'b0;
    m_ovf = 1'b0; m_cycle = 32'd0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    step_x(0, 1, MMIO_BASE + 32'h4, 0, 0, 1, 32'h0000_0001);
    step_x(0, 1, MMIO_BASE + 32'h8, 0, 0, 1, 32'd0);
    rst = 1'b0;

    // CYCLE counts from reset, then a write overrides and wraps.
    repeat (10) step(0, 0, 32'h0, 0, 0);
    step_x(0, 1, MMIO_BASE + 32'h8, 0, 0, 1, 32'd10);
    step(1, 0, MMIO_BASE + 32'h8, 32'hFFFF_FFFE, 0);
    step_x(0, 1, MMIO_BASE + 32'h8, 0, 0, 1, 32'hFFFF_FFFE);
    step(0, 0, 32'h0, 0, 0);
    step_x(0, 1, MMIO_BASE + 32'h8, 0, 0, 1, 32'd0);

    // RAM write, byte-offset alias, index wrap, read-during-write.
    step(1, 0, 32'h10, 32'hDEAD_BEEF, 0);
    step_x(0, 1, 32'h10, 0, 0, 1, 32'hDEAD_BEEF);
    step_x(0, 1, 32'h13, 0, 0, 1, 32'hDEAD_BEEF);
    step_x(0, 1, 32'h10 + 4 * MEM_WORDS, 0, 0, 1, 32'hDEAD_BEEF);
    step_x(1, 1, 32'h10, 32'h1234_5678, 0, 1, 32'hDEAD_BEEF);
    step_x(0, 1, 32'h10, 0, 0, 1, 32'h1234_5678);

    // Fill, overflow, clear overflow.
    for (int i = 0; i < 8; i++) step(1, 0, MMIO_BASE, 32'h41 + i, 0);
    step_x(0, 1, MMIO_BASE + 32'h4, 0, 0, 1, 32'h0000_0802);
    step(1, 0, MMIO_BASE, 32'h50, 0);
    step_x(0, 1, MMIO_BASE + 32'h4, 0, 0, 1, 32'h0000_0806);
    step(1, 0, MMIO_BASE + 32'h4, 32'h4, 0);
    step_x(0, 1, MMIO_BASE + 32'h4, 0, 0, 1, 32'h0000_0802);

    // Push into a full FIFO alongside a pop, then drain.
    step(1, 0, MMIO_BASE, 32'h49, 1);
    step_x(0, 1, MMIO_BASE + 32'h4, 0, 0, 1, 32'h0000_0802);
    for (int i = 0; i < 8; i++) step(0, 0, 32'h0, 0, 1);
    chk("drained_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("drained_scoreboard", sb_tx.size(), 32'd0);

    // Asynchronous reset with bytes queued.
    for (int i = 0; i < 3; i++) step(1, 0, MMIO_BASE, 32'h61 + i, 0);
    chk("pre_rst_tx_valid", {31'b0, tx_valid}, 32'd1);
    idle_inputs();
    #1;
    rst = 1'b1;
    m_fifo.delete(); sb_tx.delete(); m_ovf = 1'b0; m_cycle = 32'd0;
    #1;
    chk("async_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("async_rst_tx_data", {24'b0, tx_data}, 32'd0);
    @(posedge clk);
    #1;
    step_x(0, 1, MMIO_BASE + 32'h4, 0, 0, 1, 32'h0000_0001);
    step_x(0, 1, MMIO_BASE + 32'h8, 0, 0, 1, 32'd0);
    rst = 1'b0;

    // Reserved and unmapped addresses; disabled read.
    step_x(0, 1, MMIO_BASE + 32'hC, 0, 0, 1, 32'd0);
    step_x(0, 1, MMIO_BASE + 32'h20, 0, 0, 1, 32'd0);
    step(1, 0, MMIO_BASE + 32'hC, 32'hFFFF_FFFF, 0);
    step(1, 0, MMIO_BASE + 32'h20, 32'h0000_0041, 0);
    step(0, 0, MMIO_BASE + 32'h8, 0, 0);
    step(0, 0, 32'h10, 0, 0);

    // Randomized traffic after filling RAM with known data.
    for (int i = 0; i < MEM_WORDS; i++) step(1, 0, i * 4, $urandom, 0);
    for (int n = 0; n < 400; n++) begin
      kind  = $urandom_range(0, 9);
      r_we  = 1'($urandom_range(0, 1));
      r_re  = 1'($urandom_range(0, 1));
      r_d   = $urandom;
      r_rdy = ($urandom_range(0, 3) == 0);
      case (kind)
        0, 1, 2: r_a = $urandom_range(0, 32'hFFFE_FFFF);
        3, 4: begin
          r_a  = MMIO_BASE + $urandom_range(0, 3);
          r_we = 1'b1;
        end
        5: begin
          r_a  = MMIO_BASE + 32'h4 + $urandom_range(0, 3);
          r_we = ($urandom_range(0, 3) == 0);
        end
        6: begin
          r_a  = MMIO_BASE + 32'h8 + $urandom_range(0, 3);
          r_we = ($urandom_range(0, 7) == 0);
        end
        7: r_a = MMIO_BASE + 32'hC + $urandom_range(0, 3);
        8: r_a = $urandom_range(32'hFFFF_0010, 32'hFFFF_FFFF);
        default: begin
          r_a  = $urandom;
          r_we = 1'b0;
          r_re = 1'b0;
        end
      endcase
      step(r_we, r_re, r_a, r_d, r_rdy);
    end

    // Bounded final drain.
    k = 0;
    while (tx_valid && k < 50) begin
      step(0, 0, 32'h0, 0, 1);
      k++;
    end
    step(0, 0, 32'h0, 0, 0);
    chk("final_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("final_tx_scoreboard", sb_tx.size(), 32'd0);
    chk("final_read_queue", rd_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
